// File: rtl/btn_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : btn_debounce                                                 |
// | Description : N-channel push-button debouncer. Raw inputs are synchronised |
// |               and sampled on a tick taken from the rising edge of one      |
// |               divider-bus bit. A new level is accepted after STABLE_CNT    |
// |               consecutive differing samples. Press/release pulses are      |
// |               emitted in the cycle the debounced level changes.            |
// |               Optional macro AUTOREPEAT_EN adds per-channel auto-repeat    |
// |               press pulses while a button is held.                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module btn_debounce #(
   parameter int N_BTN        = 5,
   parameter int TICK_BIT     = 17,
   parameter int STABLE_CNT   = 4,
   parameter int REPEAT_DELAY = 32,
   parameter int REPEAT_RATE  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       div_in,
   input  logic [N_BTN-1:0]  btn_raw,
   output logic [N_BTN-1:0]  btn_level,
   output logic [N_BTN-1:0]  btn_press,
   output logic [N_BTN-1:0]  btn_release
);

   localparam logic [3:0] c_stable_last = 4'(STABLE_CNT - 1);

   logic r_tick_d;
   logic w_tick;
   logic w_unused_cfg;

   // Only the selected divider bit is used; the wrap of the 32-bit count is
   // harmless because the tick comes from that bit's 0->1 edge alone.
   assign w_unused_cfg = ^{div_in, 16'(REPEAT_DELAY), 16'(REPEAT_RATE)};

   // Registered copy of the tick bit; loaded even in reset so the first
   // cycle after reset cannot see a false rising edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tick_d <= div_in[TICK_BIT];
      end else begin
         r_tick_d <= div_in[TICK_BIT];
      end
   end

   assign w_tick = div_in[TICK_BIT] & ~r_tick_d;

   for (genvar i = 0; i < N_BTN; i++) begin : g_chan
      logic       r_sync1;
      logic       r_sync2;
      logic       r_level;
      logic       r_press;
      logic       r_release;
      logic [3:0] r_cnt;
      logic       w_accept;

      // Two-flop synchroniser for the asynchronous raw button.
      always_ff @(posedge clk) begin
         if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
         end else begin
            r_sync1 <= btn_raw[i];
            r_sync2 <= r_sync1;
         end
      end

      // Accept the new level on the tick that completes the stability run.
      assign w_accept = w_tick && (r_sync2 != r_level) && (r_cnt == c_stable_last);

`ifdef AUTOREPEAT_EN
      localparam logic [15:0] c_rep_delay  = 16'(REPEAT_DELAY);
      localparam logic [15:0] c_rep_reload = 16'(REPEAT_DELAY - REPEAT_RATE);

      logic [15:0] r_rep;
      logic [15:0] w_rep_next;

      assign w_rep_next = r_rep + 16'd1;
`endif

      // Stability counter, debounced level, edge pulses (and auto-repeat).
      always_ff @(posedge clk) begin
         if (rst) begin
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_cnt     <= 4'd0;
`ifdef AUTOREPEAT_EN
            r_rep     <= 16'd0;
`endif
         end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            if (w_tick) begin
               if (w_accept) begin
                  r_level   <= ~r_level;
                  r_cnt     <= 4'd0;
                  r_press   <= ~r_level;
                  r_release <= r_level;
               end else if (r_sync2 == r_level) begin
                  r_cnt <= 4'd0;
               end else begin
                  r_cnt <= r_cnt + 4'd1;
               end
            end
`ifdef AUTOREPEAT_EN
            // Repeat counter counts ticks while held; after the first repeat
            // it is rewound so later pulses arrive every REPEAT_RATE ticks.
            if (!r_level || w_accept) begin
               r_rep <= 16'd0;
            end else if (w_tick) begin
               if (w_rep_next == c_rep_delay) begin
                  r_rep   <= c_rep_reload;
                  r_press <= 1'b1;
               end else begin
                  r_rep <= w_rep_next;
               end
            end
`endif
         end
      end

      assign btn_level[i]   = r_level;
      assign btn_press[i]   = r_press;
      assign btn_release[i] = r_release;
   end

endmodule
`default_nettype wire

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 Parameter N_BTN, default 5: number of button channels (up, down, left, right, ok).
REQ-002 Parameter TICK_BIT, default 17: index of the divider-bus bit used as the sample clock-enable.
REQ-003 Parameter STABLE_CNT, default 4, legal range 1..15: consecutive differing samples required to accept a new level.
REQ-004 Parameter REPEAT_DELAY, default 32: ticks held before the first auto-repeat pulse.
REQ-005 Parameter REPEAT_RATE, default 8: ticks between later auto-repeat pulses.
REQ-006 Port clk, input, 1: system clock; the block uses one clock only.
REQ-007 Port rst, input, 1: reset, synchronous and active-high.
REQ-008 Port div_in, input, 32: free-running divider count from the clock divider, same clk domain.
REQ-009 Port btn_raw, input, N_BTN: asynchronous raw button inputs, active-high.
REQ-010 Port btn_level, output, N_BTN: debounced button levels.
REQ-011 Port btn_press, output, N_BTN: one-cycle pulse per accepted press or auto-repeat.
REQ-012 Port btn_release, output, N_BTN: one-cycle pulse per accepted release.

Function
REQ-013 Each btn_raw bit shall pass through a 2-flop synchronizer before any other use.
REQ-014 tick shall be a one-clk pulse, asserted when div_in[TICK_BIT] is 1 and its registered copy is 0.
REQ-015 The 32-bit wrap of div_in shall need no special handling; tick derives only from the selected bit's 0->1 edge.
REQ-016 Each channel shall keep a 4-bit stability counter cnt, updated only on tick.
REQ-017 On tick, if the synced input equals btn_level, cnt shall clear to 0.
REQ-018 On tick, if the synced input differs and cnt == STABLE_CNT-1, btn_level shall invert and cnt shall clear.
REQ-019 On tick, if the synced input differs and cnt < STABLE_CNT-1, cnt shall increment.
REQ-020 btn_press / btn_release shall assert in the same clk cycle that btn_level rises / falls, for exactly one cycle.
REQ-021 Latency: an input change held stable reaches btn_level on the STABLE_CNT-th tick after the synchronizer output changes.
REQ-022 A glitch shorter than STABLE_CNT ticks shall never change btn_level.
REQ-023 Channels shall be fully independent; simultaneous changes on several channels shall each follow REQ-017..020.
REQ-024 Between ticks, all channel state shall hold its value.

Reset
REQ-025 While rst=1, at each clk edge: btn_level, btn_press, btn_release, all cnt, synchronizers and repeat counters shall clear to 0.
REQ-026 While rst=1, the registered tick bit shall load div_in[TICK_BIT], so no spurious tick occurs in the first cycle after reset.
REQ-027 Reset asserted mid-debounce or mid-repeat shall abort it; no press or release pulse shall be emitted for that edge.

Configuration
REQ-028 Macro AUTOREPEAT_EN defined: while btn_level=1, a per-channel tick counter shall run; the first extra btn_press pulse comes REPEAT_DELAY ticks after the accepted press; further pulses follow every REPEAT_RATE ticks; the counter clears when btn_level falls.
REQ-029 Macro AUTOREPEAT_EN undefined: no repeat logic is built, and btn_press pulses once per accepted press only.

Verification
REQ-030 Bench parameters: TICK_BIT=2 (tick every 8 clk), STABLE_CNT=4.
REQ-031 Press test: btn_raw[0] 0->1, held 100 clk -> btn_level[0]=1 on the 4th tick after the sync change; btn_press[0] high exactly 1 cycle; other channels stay 0.
REQ-032 Glitch test: btn_raw[1] high for 20 clk (<4 ticks), then low -> btn_level[1], btn_press[1] and btn_release[1] stay 0 throughout.
REQ-033 Release and simultaneous test: btn_raw[2] and btn_raw[3] both fall after being held high -> both btn_release pulse in the same cycle, 4 ticks after the sync change.
REQ-034 Reset test: assert rst for 1 clk after the 3rd differing tick -> all outputs 0, no press pulse; div_in[2]=1 at reset release -> no tick in the first cycle.
REQ-035 Wrap test: preload div_in from 32'hFFFF_FFF0 through the wrap -> tick spacing stays 8 clk and a debounce spanning the wrap completes normally.
REQ-036 AUTOREPEAT_EN test (REPEAT_DELAY=4, REPEAT_RATE=2): hold btn_raw[4] -> btn_press[4] pulses at the accepted press, then 4 ticks later, then every 2 ticks; without the macro, exactly one pulse.
